barrel_shifter_pipe: RTL and testbench

Parametrised, pipelined successor to the 64-bit combinational barrel shifter. It accepts one shift operation per cycle over a valid/ready handshake and splits the log2(WIDTH) mux levels across STAGES register stages. It adds rotate mode, a carry-out flag and full backpressure. It sits between the ALU operand bus and the result writeback arbiter.

---
 rtl/barrel_shift_pkg.sv | 42 ++++
 rtl/barrel_shift_level.sv | 40 ++++
 rtl/barrel_shifter_pipe.sv | 154 +++++++++++++++
 tb/tb_barrel_shifter_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
//   shift_op_e      : operation encoding carried on the op port
//   level_range_t   : first mux level and level count owned by one stage
//   stage_ctrl_t    : control payload carried alongside the data between stages
//   levels_in_stage : even split of SH_W mux levels over STAGES stages,
//                     with earlier stages taking the remainder
package barrel_shift_pkg;

  typedef enum logic [1:0] {
    OP_LOGIC = 2'b00,
    OP_ARITH = 2'b01,
    OP_ROT   = 2'b10,
    OP_RSVD  = 2'b11
  } shift_op_e;

  typedef struct packed {
    logic [7:0] first;
    logic [7:0] count;
  } level_range_t;

  // The data word and the remaining sh_amt bits are carried next to this
  // struct; their widths depend on the instance parameters.
  typedef struct packed {
    logic      dir;
    shift_op_e op;
    logic      msb;
  } stage_ctrl_t;

  function automatic level_range_t levels_in_stage(input int unsigned stage,
                                                   input int unsigned sh_w,
                                                   input int unsigned stages);
    int unsigned base;
    int unsigned rem;
    level_range_t r;
    base    = sh_w / stages;
    rem     = sh_w % stages;
    r.first = 8'(stage * base + ((stage < rem) ? stage : rem));
    r.count = 8'(base + ((stage < rem) ? 1 : 0));
    return r;
  endfunction

endpackage

// File: rtl/barrel_shift_level.sv
// One combinational mux level of the barrel shifter: shifts or rotates by
// DIST when sel is set, otherwise passes data through.
//   data   : word entering this level
//   sel    : sh_amt bit owned by this level
//   dir    : 0 = left, 1 = right
//   op     : logical / arithmetic / rotate (reserved acts as logical)
//   msb    : original operand MSB, the fill for arithmetic right shifts
//   result : word leaving this level
module barrel_shift_level
  import barrel_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             sel,
  input  logic             dir,
  input  shift_op_e        op,
  input  logic             msb,
  output logic [WIDTH-1:0] result
);

  logic [DIST-1:0] fill;

  always_comb begin
    fill   = (op == OP_ARITH && dir) ? {DIST{msb}} : '0;
    result = data;
    if (sel) begin
      if (op == OP_ROT) begin
        result = dir ? {data[DIST-1:0], data[WIDTH-1:DIST]}
                     : {data[WIDTH-DIST-1:0], data[WIDTH-1:WIDTH-DIST]};
      end else begin
        // Left arithmetic is zero fill, so fill is only non-zero going right.
        result = dir ? {fill, data[WIDTH-1:DIST]}
                     : {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
      end
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter with valid/ready handshake on both sides.
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid, in_ready : input handshake
//   d_in, sh_amt       : operand and shift distance
//   dir, op            : 0 = left / 1 = right; 00 logical, 01 arith, 10 rotate
//   out_valid, out_ready : output handshake
//   d_out, z, c        : result, zero flag, carry-out
// The SH_W mux levels are split across STAGES registered stages; latency is
// STAGES cycles with one operation accepted per cycle.
module barrel_shifter_pipe
  import barrel_shift_pkg::*;
#(
  parameter  int unsigned WIDTH  = 64,
  parameter  int unsigned STAGES = 3,
  localparam int unsigned SH_W   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_in,
  input  logic [SH_W-1:0]  sh_amt,
  input  logic             dir,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             z,
  output logic             c
);

  logic             valid_q [STAGES];
  logic             adv     [STAGES];
  logic [WIDTH-1:0] data_q  [STAGES];
  logic             c_q     [STAGES];
  logic             z_q;

  // Carry-out only depends on the original operand: for rotates the bit that
  // wraps into d_out[0] / d_out[WIDTH-1] is the same bit a plain shift would
  // drop, so one expression serves every mode.
  logic [SH_W-1:0] idx_l;
  logic [SH_W-1:0] idx_r;
  logic            c_in;

  assign idx_l = '0 - sh_amt;
  assign idx_r = sh_amt - SH_W'(1);
  assign c_in  = (sh_amt == '0) ? 1'b0 : (dir ? d_in[idx_r] : d_in[idx_l]);

  always_comb begin
    adv[STAGES-1] = !valid_q[STAGES-1] || out_ready;
    for (int unsigned i = 1; i < STAGES; i++) begin
      adv[STAGES-1-i] = !valid_q[STAGES-1-i] || adv[STAGES-i];
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[STAGES-1];
  assign d_out     = data_q[STAGES-1];
  assign c         = c_q[STAGES-1];
  assign z         = z_q;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam level_range_t RNG = levels_in_stage(s, SH_W, STAGES);
    localparam int unsigned FIRST  = int'(RNG.first);
    localparam int unsigned CNT    = int'(RNG.count);
    localparam int unsigned REM_IN = SH_W - FIRST;

    logic              in_v;
    logic [WIDTH-1:0]  src;
    logic [REM_IN-1:0] src_sh;
    stage_ctrl_t       src_ctrl;
    logic              src_c;
    logic [WIDTH-1:0]  nxt;

    if (s == 0) begin : g_head
      assign in_v         = in_valid;
      assign src          = d_in;
      assign src_sh       = sh_amt;
      assign src_ctrl.dir = dir;
      assign src_ctrl.op  = shift_op_e'(op);
      assign src_ctrl.msb = d_in[WIDTH-1];
      assign src_c        = c_in;
    end else begin : g_tail
      // Bit 0 of the forwarded remainder is the lowest level this stage owns.
      assign in_v     = valid_q[s-1];
      assign src      = data_q[s-1];
      assign src_sh   = g_stage[s-1].g_fwd.sh_q;
      assign src_ctrl = g_stage[s-1].g_fwd.ctrl_q;
      assign src_c    = c_q[s-1];
    end

    for (genvar j = 0; j < CNT; j++) begin : g_lvl
      logic [WIDTH-1:0] prev;
      logic [WIDTH-1:0] res;
      if (j == 0) begin : g_first
        assign prev = src;
      end else begin : g_next
        assign prev = g_lvl[j-1].res;
      end
      barrel_shift_level #(
        .WIDTH (WIDTH),
        .DIST  (2 ** (FIRST + j))
      ) u_level (
        .data   (prev),
        .sel    (src_sh[j]),
        .dir    (src_ctrl.dir),
        .op     (src_ctrl.op),
        .msb    (src_ctrl.msb),
        .result (res)
      );
    end

    assign nxt = g_lvl[CNT-1].res;

    // Payload only loads with a valid op so d_out/z/c hold while idle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q[s] <= 1'b0;
        data_q[s]  <= '0;
        c_q[s]     <= 1'b0;
      end else if (adv[s]) begin
        valid_q[s] <= in_v;
        if (in_v) begin
          data_q[s] <= nxt;
          c_q[s]    <= src_c;
        end
      end
    end

    if (s < STAGES - 1) begin : g_fwd
      localparam int unsigned REM_OUT = REM_IN - CNT;
      logic [REM_OUT-1:0] sh_q;
      stage_ctrl_t        ctrl_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sh_q   <= '0;
          ctrl_q <= '0;
        end else if (adv[s] && in_v) begin
          sh_q   <= src_sh[REM_IN-1:CNT];
          ctrl_q <= src_ctrl;
        end
      end
    end else begin : g_last
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          z_q <= 1'b0;
        end else if (adv[s] && in_v) begin
          z_q <= (nxt == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
module tb_barrel_shifter_pipe;

  localparam int unsigned W  = 64;
  localparam int unsigned ST = 3;
  localparam int unsigned SW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  d_in;
  logic [SW-1:0] sh_amt;
  logic          dir;
  logic [1:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  d_out;
  logic          z;
  logic          c;

  barrel_shifter_pipe #(.WIDTH(W), .STAGES(ST)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_in      (d_in),
    .sh_amt    (sh_amt),
    .dir       (dir),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d_out     (d_out),
    .z         (z),
    .c         (c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         z;
    logic         c;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           n_total = 0;
  int           n_bad   = 0;
  int           cyc     = 0;
  int           last_pop = -1000;
  logic         stall_prev = 1'b0;
  logic [W-1:0] held_d;
  logic         held_z;
  logic         held_c;
  logic         took;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: straight shift/rotate arithmetic on the whole word.
  function automatic exp_t ref_op(input logic [W-1:0] d, input int unsigned n,
                                  input logic dr, input logic [1:0] o);
    exp_t e;
    logic [W-1:0] r;
    logic cc;
    if (o == 2'b10) begin
      r  = dr ? ((d >> n) | (d << (W - n))) : ((d << n) | (d >> (W - n)));
      cc = (n == 0) ? 1'b0 : (dr ? r[W-1] : r[0]);
    end else begin
      if (dr && o == 2'b01) r = W'($signed(d) >>> n);
      else                  r = dr ? (d >> n) : (d << n);
      cc = (n == 0) ? 1'b0 : (dr ? d[n-1] : d[W-n]);
    end
    e.data = r;
    e.z    = (r == '0);
    e.c    = cc;
    e.acc  = 0;
    return e;
  endfunction

  // Called with inputs already driven, shortly after a rising edge.
  task automatic step();
    exp_t e;
    int   rdy;
    #1;
    check("in_ready", W'(in_ready), W'((q.size() < ST) || out_ready));
    rdy = 0;
    if (q.size() > 0) begin
      rdy = q[0].acc + ST;
      if (last_pop + 1 > rdy) rdy = last_pop + 1;
    end
    check("out_valid", W'(out_valid), W'(q.size() > 0 && cyc >= rdy));
    if (stall_prev) begin
      check("hold_d_out", d_out, held_d);
      check("hold_z", W'(z), W'(held_z));
      check("hold_c", W'(c), W'(held_c));
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_result", W'(1), W'(0));
      end else begin
        e = q.pop_front();
        check("d_out", d_out, e.data);
        check("z", W'(z), W'(e.z));
        check("c", W'(c), W'(e.c));
        last_pop = cyc;
      end
    end
    took = in_valid && in_ready;
    if (took) begin
      e     = ref_op(d_in, int'(sh_amt), dir, op);
      e.acc = cyc;
      q.push_back(e);
    end
    stall_prev = out_valid && !out_ready;
    held_d = d_out;
    held_z = z;
    held_c = c;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_op(input logic [W-1:0] d, input int unsigned n,
                         input logic dr, input logic [1:0] o);
    int guard = 0;
    d_in = d; sh_amt = SW'(n); dir = dr; op = o; in_valid = 1'b1;
    took = 1'b0;
    while (!took && guard < 50) begin
      step();
      guard++;
    end
    if (!took) check("accept_timeout", W'(0), W'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    while (q.size() > 0 && guard < 50) begin
      step();
      guard++;
    end
    if (q.size() > 0) check("drain_timeout", W'(q.size()), W'(0));
    step();
  endtask

  initial begin
    int accepted;
    int first_drop;
    int rel;
    rst = 1'b1; in_valid = 1'b0; d_in = '0; sh_amt = '0; dir = 1'b0;
    op = 2'b00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_d_out", d_out, W'(0));
    check("rst_z", W'(z), W'(0));
    check("rst_c", W'(c), W'(0));
    rst = 1'b0;
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;

    // Directed operations from the plan, each isolated so latency is exact.
    send_op(64'h5, 3, 1'b0, 2'b00);                 drain();
    send_op(64'hFFFF_FFFF_FFFF_FFF0, 2, 1'b1, 2'b01); drain();
    send_op(64'hFFFF_FFFF_FFFF_FFF0, 5, 1'b1, 2'b01); drain();
    send_op(64'h8000_0000_0000_0001, 1, 1'b0, 2'b10); drain();
    send_op(64'h1, 1, 1'b1, 2'b00);                 drain();
    send_op(64'h8000_0000_0000_0000, 63, 1'b1, 2'b01); drain();
    send_op(64'hA5A5_0000_1234_5677, 63, 1'b0, 2'b00); drain();
    send_op(64'h0123_4567_89AB_CDEF, 0, 1'b1, 2'b10); drain();
    send_op(64'h0123_4567_89AB_CDEF, 17, 1'b1, 2'b11); drain();
    send_op(64'h8123_4567_89AB_CDEF, 9, 1'b0, 2'b01); drain();

    // Back-to-back stream of 8 with out_ready low for relative cycles 4..9.
    accepted = 0; first_drop = -1; rel = 0;
    while ((accepted < 8 || q.size() > 0) && rel < 60) begin
      out_ready = !(rel >= 4 && rel <= 9);
      in_valid  = (accepted < 8);
      d_in      = {$urandom, $urandom};
      sh_amt    = SW'($urandom_range(0, W - 1));
      dir       = 1'(rel);
      op        = 2'(rel % 3);
      #1;
      if (accepted < 8 && !in_ready && first_drop < 0) first_drop = accepted;
      step();
      if (took) accepted++;
      rel++;
    end
    in_valid = 1'b0;
    check("stream_accepts", W'(accepted), W'(8));
    check("accepts_before_full", W'(first_drop), W'(ST + 1));
    drain();

    // Randomized traffic with random backpressure and boundary shift amounts.
    took = 1'b1;
    for (int unsigned i = 0; i < 400; i++) begin
      if (took || !in_valid) begin
        in_valid = ($urandom_range(0, 9) < 7);
        d_in     = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0:       sh_amt = '0;
          1:       sh_amt = SW'(W - 1);
          default: sh_amt = SW'($urandom_range(0, W - 1));
        endcase
        dir = 1'($urandom);
        op  = 2'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid = 1'b0;
    drain();

    // Reset with two operations in flight.
    send_op(64'hDEAD_BEEF_0000_0001, 4, 1'b0, 2'b00);
    send_op(64'h0000_0000_FFFF_0000, 8, 1'b1, 2'b01);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_d_out", d_out, W'(0));
    q.delete();
    stall_prev = 1'b0;
    last_pop = -1000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_in_ready", W'(in_ready), W'(1));
    out_ready = 1'b1;
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
